rtsnoc_traffic_gen: RTL and testbench

RTSNOC_TRAFFIC_GEN -- requirements
Module: rtsnoc_traffic_gen

---
 rtl/rtsnoc_traffic_gen.sv | 158 +++++++++++++++
 tb/tb_rtsnoc_traffic_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtsnoc_traffic_gen.sv
`default_nettype none
// rtsnoc_traffic_gen: sends numbered request flits to an echo node on the RTSNoC mesh
// and scores each response as a match, a mismatch or a timeout.
module rtsnoc_traffic_gen #(
  parameter int         SOC_SIZE_X     = 1,
  parameter int         SOC_SIZE_Y     = 1,
  parameter int         NOC_DATA_WIDTH = 16,
  parameter int         LOCAL_X        = 0,
  parameter int         LOCAL_Y        = 0,
  parameter logic [2:0] LOCAL_H        = 3'd1,
  parameter int         DEST_X         = 0,
  parameter int         DEST_Y         = 0,
  parameter logic [2:0] DEST_H         = 3'd0,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [11:0] count_i,
  input  logic [15:0] seed_i,
  output logic [37:0] din_o,
  output logic        wr_o,
  input  logic        wait_i,
  input  logic [37:0] dout_i,
  input  logic        nd_i,
  output logic        rd_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [11:0] sent_o,
  output logic [11:0] rcvd_o,
  output logic [11:0] err_o
);

  localparam int ADDR_W = 3 + SOC_SIZE_Y + SOC_SIZE_X;
  localparam logic [ADDR_W-1:0] LOCAL_ADDR =
    {LOCAL_H, SOC_SIZE_Y'(LOCAL_Y), SOC_SIZE_X'(LOCAL_X)};
  localparam logic [ADDR_W-1:0] DEST_ADDR =
    {DEST_H, SOC_SIZE_Y'(DEST_Y), SOC_SIZE_X'(DEST_X)};
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] WAIT_RSP = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]                state;
  logic [11:0]               count_q;
  logic [11:0]               idx;
  logic [NOC_DATA_WIDTH-1:0] seed_q;
  logic [15:0]               tmo_cnt;
  logic                      rd_q;

  logic [11:0]               idx_next;
  logic [NOC_DATA_WIDTH-1:0] data_exp;
  logic [NOC_DATA_WIDTH-1:0] data_next;
  logic                      rsp_match;
  logic                      expire;
  logic                      start_run;
  logic [1:0]                err_inc;

  function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [1:0] inc);
    logic [12:0] s;
    s = {1'b0, a} + {11'd0, inc};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

  // Pop at most every other cycle so the router can retire the flit before the next read.
  assign rd_o = rst_i & nd_i & ~rd_q;

  assign wr_o   = (state == SEND);
  assign busy_o = (state == SEND) || (state == WAIT_RSP);
  assign done_o = (state == DONE);

  assign idx_next  = idx + 12'd1;
  assign data_exp  = seed_q + NOC_DATA_WIDTH'(idx);
  assign data_next = seed_q + NOC_DATA_WIDTH'(idx_next);
  assign start_run = (state == IDLE) && start_i;

  // The echo node swaps source and destination, so the response header is reversed.
  assign rsp_match = rd_o && (state == WAIT_RSP) &&
                     (dout_i == {LOCAL_ADDR, DEST_ADDR, idx, data_exp});
  assign expire    = (state == WAIT_RSP) && (tmo_cnt == TMO_LAST);

  // A response landing on the expiry cycle wins over the timeout.
  assign err_inc = {1'b0, rd_o && !rsp_match} + {1'b0, expire && !rsp_match};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      count_q   <= '0;
      idx       <= '0;
      seed_q    <= '0;
      tmo_cnt   <= '0;
      rd_q      <= 1'b0;
      din_o     <= '0;
      timeout_o <= 1'b0;
      sent_o    <= '0;
      rcvd_o    <= '0;
      err_o     <= '0;
    end else begin
      rd_q  <= rd_o;
      err_o <= sat_add(start_run ? 12'd0 : err_o, err_inc);
      case (state)
        IDLE: begin
          if (start_i) begin
            count_q   <= count_i;
            seed_q    <= seed_i;
            idx       <= '0;
            tmo_cnt   <= '0;
            sent_o    <= '0;
            rcvd_o    <= '0;
            timeout_o <= 1'b0;
            if (count_i != 12'd0) begin
              state <= SEND;
              din_o <= {DEST_ADDR, LOCAL_ADDR, 12'd0, seed_i};
            end else begin
              state <= DONE;
            end
          end
        end
        SEND: begin
          if (!wait_i) begin
            sent_o  <= sat_add(sent_o, 2'd1);
            tmo_cnt <= '0;
            state   <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          tmo_cnt <= tmo_cnt + 16'd1;
          if (rsp_match) begin
            rcvd_o <= sat_add(rcvd_o, 2'd1);
          end
          if (rsp_match || expire) begin
            if (!rsp_match) begin
              timeout_o <= 1'b1;
            end
            idx <= idx_next;
            if (idx_next == count_q) begin
              state <= DONE;
            end else begin
              state <= SEND;
              din_o <= {DEST_ADDR, LOCAL_ADDR, idx_next, data_next};
            end
          end
        end
        DONE: begin
          if (!start_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rtsnoc_traffic_gen.sv
`default_nettype none
// tb_rtsnoc_traffic_gen: directed bench around a router/echo-node model that swaps
// source and destination and returns each accepted flit about three cycles later.
module tb_rtsnoc_traffic_gen;

  // Local 0/1/1 and destination 1/0/2, so header fields are all distinguishable.
  localparam logic [9:0] REQ_HDR = 10'b010_0_1_001_1_0;
  localparam logic [9:0] RSP_HDR = 10'b001_1_0_010_0_1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [11:0] count;
  logic [15:0] seed;
  logic [37:0] din;
  logic        wr;
  logic        router_wait;
  logic [37:0] dout;
  logic        nd;
  logic        rd;
  logic        busy, done, timeout;
  logic [11:0] sent, rcvd, err;

  rtsnoc_traffic_gen #(
    .LOCAL_X(0), .LOCAL_Y(1), .LOCAL_H(3'd1),
    .DEST_X(1), .DEST_Y(0), .DEST_H(3'd2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .count_i(count), .seed_i(seed),
    .din_o(din), .wr_o(wr), .wait_i(router_wait),
    .dout_i(dout), .nd_i(nd), .rd_o(rd),
    .busy_o(busy), .done_o(done), .timeout_o(timeout),
    .sent_o(sent), .rcvd_o(rcvd), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [37:0] flit;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [37:0] rx_q[$];
  logic [37:0] sent_log[$];
  logic [37:0] rsp_tmp;
  int          cyc = 0;
  int          rd_pulses = 0;
  logic        echo_en = 1'b0;
  logic        corrupt1 = 1'b0;
  logic        inject = 1'b0;
  logic [37:0] inject_flit = '0;

  int checks = 0;
  int failures = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q.delete();
      rx_q.delete();
      nd   <= 1'b0;
      dout <= '0;
    end else begin
      cyc++;
      if (rd) begin
        rd_pulses++;
        if (rx_q.size() > 0) void'(rx_q.pop_front());
      end
      if (wr && !router_wait) begin
        sent_log.push_back(din);
        if (echo_en) begin
          rsp_tmp = {din[32:28], din[37:33], din[27:0]};
          if (corrupt1 && din[27:16] == 12'd1)
            pend_q.push_back(pend_t'{rsp_tmp ^ 38'd1, cyc + 3});
          pend_q.push_back(pend_t'{rsp_tmp, cyc + 3});
        end
      end
      if (inject) rx_q.push_back(inject_flit);
      while (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        rx_q.push_back(pend_q[0].flit);
        void'(pend_q.pop_front());
      end
      nd   <= (rx_q.size() > 0);
      dout <= (rx_q.size() > 0) ? rx_q[0] : '0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {63'd0, done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int stable;
    logic [37:0] exp_flit;

    rst = 1'b1;
    start = 1'b0;
    count = '0;
    seed = '0;
    router_wait = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_wr", {63'd0, wr}, 64'd0);
    chk("rst_rd", {63'd0, rd}, 64'd0);
    chk("rst_din", {26'd0, din}, 64'd0);
    chk("rst_flags", {61'd0, busy, done, timeout}, 64'd0);
    chk("rst_counters", {28'd0, sent, rcvd, err}, 64'd0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);

    // Unsolicited flit in IDLE: popped once, counted as an error.
    base = rd_pulses;
    inject_flit = {RSP_HDR, 12'h055, 16'h7777};
    inject = 1'b1;
    @(negedge clk) inject = 1'b0;
    repeat (5) @(negedge clk);
    chk("unsol_rd_pulses", 64'(rd_pulses - base), 64'd1);
    chk("unsol_err", {52'd0, err}, 64'd1);
    chk("unsol_idle", {61'd0, busy, done, wr}, 64'd0);

    // Four packets through the echo model.
    echo_en = 1'b1;
    count = 12'd4;
    seed = 16'h1000;
    base = sent_log.size();
    start = 1'b1;
    wait_done("echo4_done", 300, n);
    chk("echo4_sent", {52'd0, sent}, 64'd4);
    chk("echo4_rcvd", {52'd0, rcvd}, 64'd4);
    chk("echo4_err", {52'd0, err}, 64'd0);
    chk("echo4_timeout", {63'd0, timeout}, 64'd0);
    chk("echo4_nflits", 64'(sent_log.size() - base), 64'd4);
    for (int k = 0; k < 4; k++) begin
      exp_flit = {REQ_HDR, 12'(k), 16'h1000 + 16'(k)};
      if (base + k < sent_log.size())
        chk($sformatf("echo4_flit%0d", k), {26'd0, sent_log[base + k]}, {26'd0, exp_flit});
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("echo4_idle_done", {63'd0, done}, 64'd0);
    chk("echo4_idle_hold", {40'd0, sent, rcvd}, {40'd0, 12'd4, 12'd4});

    // Back-pressure on the first SEND for ten cycles.
    router_wait = 1'b1;
    count = 12'd1;
    seed = 16'hABCD;
    start = 1'b1;
    @(negedge clk);
    exp_flit = {REQ_HDR, 12'd0, 16'hABCD};
    stable = 1;
    repeat (10) begin
      if (wr !== 1'b1 || din !== exp_flit) stable = 0;
      @(negedge clk);
    end
    chk("bp_hold_stable", 64'(stable), 64'd1);
    chk("bp_sent_held", {52'd0, sent}, 64'd0);
    router_wait = 1'b0;
    @(negedge clk);
    chk("bp_sent_once", {52'd0, sent}, 64'd1);
    chk("bp_wr_drop", {63'd0, wr}, 64'd0);
    wait_done("bp_done", 100, n);
    chk("bp_rcvd", {52'd0, rcvd}, 64'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // No responder: both packets time out after 16 cycles each.
    echo_en = 1'b0;
    count = 12'd2;
    seed = 16'h0000;
    start = 1'b1;
    wait_done("tmo_done", 200, n);
    chk("tmo_latency", 64'(n), 64'd35);
    chk("tmo_flag", {63'd0, timeout}, 64'd1);
    chk("tmo_err", {52'd0, err}, 64'd2);
    chk("tmo_rcvd", {52'd0, rcvd}, 64'd0);
    chk("tmo_sent", {52'd0, sent}, 64'd2);
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Corrupted echo for packet 1, then a good one; data wraps past 16'hFFFF.
    echo_en = 1'b1;
    corrupt1 = 1'b1;
    count = 12'd3;
    seed = 16'hFFFE;
    base = sent_log.size();
    start = 1'b1;
    wait_done("corr_done", 300, n);
    chk("corr_err", {52'd0, err}, 64'd1);
    chk("corr_rcvd", {52'd0, rcvd}, 64'd3);
    chk("corr_sent", {52'd0, sent}, 64'd3);
    chk("corr_timeout_cleared", {63'd0, timeout}, 64'd0);
    if (base + 2 < sent_log.size())
      chk("corr_wrap_flit", {26'd0, sent_log[base + 2]}, {26'd0, REQ_HDR, 12'd2, 16'h0000});
    else
      chk("corr_wrap_nflits", 64'(sent_log.size() - base), 64'd3);
    corrupt1 = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Reset asserted while waiting for a response, then a fresh single-packet run.
    echo_en = 1'b0;
    count = 12'd2;
    seed = 16'h0005;
    start = 1'b1;
    repeat (5) @(negedge clk);
    chk("rstmid_busy_before", {63'd0, busy}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_flags", {60'd0, busy, done, timeout, wr}, 64'd0);
    chk("rstmid_rd", {63'd0, rd}, 64'd0);
    chk("rstmid_din", {26'd0, din}, 64'd0);
    chk("rstmid_counters", {28'd0, sent, rcvd, err}, 64'd0);
    echo_en = 1'b1;
    count = 12'd1;
    seed = 16'h0042;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rstmid_no_wr_first", {63'd0, wr}, 64'd0);
    wait_done("restart_done", 100, n);
    chk("restart_sent", {52'd0, sent}, 64'd1);
    chk("restart_rcvd", {52'd0, rcvd}, 64'd1);
    chk("restart_err", {52'd0, err}, 64'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
